// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared types and round-robin channel pick for the demux scheduler
package demux_sched_pkg;
    typedef logic [1:0] chan_sel_t;
    typedef enum logic {IDLE, HOLD} sched_state_e;
    localparam int NUM_CH = 4;
    // descending scan so the lowest offset from ptr wins
    function automatic chan_sel_t rr_pick(input logic [NUM_CH-1:0] en, input chan_sel_t ptr);
        chan_sel_t c;
        rr_pick = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = ptr + chan_sel_t'(i);
            if (en[c]) rr_pick = c;
        end
    endfunction
endpackage

// File: rtl/demux4_onehot.sv
// demux4_onehot: gate-level 1-to-4 demux of a valid bit onto the selected channel
module demux4_onehot
    import demux_sched_pkg::*;
(
    input  logic              valid,
    input  chan_sel_t         sel,
    output logic [NUM_CH-1:0] out_valid
);
    assign out_valid = {3'b000, valid} << sel;
endmodule

// File: rtl/demux4_rr_sched.sv
// demux4_rr_sched: round-robin scheduler feeding a 1-to-4 demux through a one-entry output register
// Optional work-conserving channel choice with DEMUX_SCHED_SKIP_EN.
module demux4_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              in_valid,
    input  logic [W-1:0]      in_data,
    output logic              in_ready,
    output chan_sel_t         sel,
    output logic [W-1:0]      out_data,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic              busy
);
    sched_state_e state;
    chan_sel_t    ptr;
    chan_sel_t    pick;
    logic         drain;
    logic         accept;
    assign busy     = state == HOLD;
    assign drain    = busy && out_ready[sel];
    assign in_ready = |chan_en && (!busy || drain);
    assign accept   = in_valid && in_ready;
`ifdef DEMUX_SCHED_SKIP_EN
    // prefer a channel whose consumer is ready, so a stalled one is passed over
    assign pick = |(chan_en & out_ready) ? rr_pick(chan_en & out_ready, ptr) : rr_pick(chan_en, ptr);
`else
    assign pick = rr_pick(chan_en, ptr);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            out_data <= '0;
        end else if (accept) begin
            state    <= HOLD;
            ptr      <= pick + 2'd1;
            sel      <= pick;
            out_data <= in_data;
        end else if (drain) begin
            state    <= IDLE;
        end
    end
    demux4_onehot u_onehot (
        .valid     (busy),
        .sel       (sel),
        .out_valid (out_valid)
    );
endmodule

// File: tb/tb_demux4_rr_sched.sv
// tb_demux4_rr_sched: directed and randomized checks of demux4_rr_sched against a behavioural model
module tb_demux4_rr_sched;
`ifdef DEMUX_SCHED_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] chan_en;
    logic       in_valid;
    logic [0:0] in_data;
    logic       in_ready;
    logic [1:0] sel;
    logic [0:0] out_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic       busy;
    int n_chk = 0;
    int n_fail = 0;
    bit armed = 1'b0;
    bit m_full;
    int m_ptr, m_sel;
    logic m_data;
    bit m_drain;
    logic d1 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ov1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    demux4_rr_sched #(.W(1)) dut (
        .clk(clk), .rst(rst), .chan_en(chan_en), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sel(sel), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int choose(input logic [3:0] en, input logic [3:0] rdy, input int p);
        if (SKIP)
            for (int k = 0; k < 4; k++)
                if (en[(p + k) % 4] && rdy[(p + k) % 4]) return (p + k) % 4;
        for (int k = 0; k < 4; k++)
            if (en[(p + k) % 4]) return (p + k) % 4;
        return p;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            armed = 1'b1;
            m_full = 1'b0;
            m_ptr = 0;
            m_sel = 0;
            m_data = 1'b0;
        end else if (armed) begin
            m_drain = m_full && out_ready[m_sel];
            if (in_valid && chan_en != 4'b0 && (!m_full || m_drain)) begin
                m_sel = choose(chan_en, out_ready, m_ptr);
                m_ptr = (m_sel + 1) % 4;
                m_data = in_data;
                m_full = 1'b1;
            end else if (m_drain) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model in_ready", 4'(in_ready), 4'((chan_en != 4'b0) && (!m_full || out_ready[m_sel])));
            check("model busy", 4'(busy), 4'(m_full));
            check("model out_valid", out_valid, m_full ? 4'b0001 << m_sel : 4'b0000);
            check("model sel", 4'(sel), 4'(m_sel));
            check("model out_data", 4'(out_data), 4'(m_data));
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        chan_en = 4'b1111;
        in_valid = 1'b0;
        in_data = 1'b0;
        out_ready = 4'b1111;
        repeat (2) @(negedge clk);
        check("reset busy", 4'(busy), 4'b0);
        check("reset out_valid", out_valid, 4'b0000);
        check("reset sel", 4'(sel), 4'b0);
        check("reset out_data", 4'(out_data), 4'b0);
        check("reset in_ready any_en", 4'(in_ready), 4'b1);
        #1 chan_en = 4'b0000;
        #1 check("reset in_ready no_en", 4'(in_ready), 4'b0);
        rst = 1'b0;
        // full rotation with everyone ready
        chan_en = 4'b1111;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = d1[i];
            @(negedge clk);
            check("rot sel", 4'(sel), 4'(i % 4));
            check("rot out_valid", out_valid, ov1[i]);
            check("rot out_data", 4'(out_data), 4'(d1[i]));
            #1;
        end
        // only channels 0 and 2 enabled
        do_reset;
        chan_en = 4'b0101;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 1'($urandom);
            @(negedge clk);
            check("alt sel", 4'(sel), 4'((i % 2) * 2));
            check("alt ch1/ch3 idle", 4'({out_valid[3], out_valid[1]}), 4'b0);
            #1;
        end
        // stall on channel 1
        do_reset;
        chan_en = 4'b1111;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        in_data = 1'b1;
        @(negedge clk);
        #1 in_data = 1'b0;
        @(negedge clk);
        check("stall sel", 4'(sel), 4'd1);
        #1 out_ready = 4'b1101;
        in_data = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall out_valid", out_valid, 4'b0010);
            check("stall out_data", 4'(out_data), 4'b0);
            check("stall in_ready", 4'(in_ready), 4'b0);
            #1;
        end
        out_ready = 4'b1111;
        #1 check("release in_ready", 4'(in_ready), 4'b1);
        @(negedge clk);
        check("release sel", 4'(sel), 4'd2);
        check("release out_valid", out_valid, 4'b0100);
        check("release out_data", 4'(out_data), 4'b1);
        #1;
        // no channel enabled
        do_reset;
        chan_en = 4'b0000;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("noen in_ready", 4'(in_ready), 4'b0);
            check("noen busy", 4'(busy), 4'b0);
            #1;
        end
        chan_en = 4'b1000;
        @(negedge clk);
        check("en3 sel", 4'(sel), 4'd3);
        check("en3 out_valid", out_valid, 4'b1000);
        #1;
        // reset while holding
        do_reset;
        chan_en = 4'b1111;
        out_ready = 4'b0000;
        in_valid = 1'b1;
        @(negedge clk);
        check("hold busy", 4'(busy), 4'b1);
        check("hold out_valid", out_valid, 4'b0001);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst hold out_valid", out_valid, 4'b0000);
        check("rst hold busy", 4'(busy), 4'b0);
        #1 rst = 1'b0;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        in_data = 1'b1;
        @(negedge clk);
        check("rst ptr sel", 4'(sel), 4'd0);
        #1;
        // ptr=1 with channel 1 stalled
        do_reset;
        chan_en = 4'b1111;
        out_ready = 4'b1111;
        in_valid = 1'b1;
        @(negedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("skip pre busy", 4'(busy), 4'b0);
        #1 out_ready = 4'b1101;
        in_valid = 1'b1;
        in_data = 1'b1;
        @(negedge clk);
        check("skip sel", 4'(sel), SKIP ? 4'd2 : 4'd1);
        check("skip out_valid", out_valid, SKIP ? 4'b0100 : 4'b0010);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("skip after", out_valid, SKIP ? 4'b0000 : 4'b0010);
        #1;
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 97) == 0;
            chan_en = ($urandom % 8 == 0) ? 4'b0000 : 4'($urandom);
            in_valid = ($urandom % 4) != 0;
            in_data = 1'($urandom);
            out_ready = 4'($urandom) | 4'($urandom);
            @(negedge clk);
            #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/demux4_rr_sched.md
# demux4_rr_sched

Round-robin scheduler that shares one input stream across four destinations through the 1-to-4 demultiplexer datapath. It accepts words on a valid/ready input, picks the destination channel, drives the 2-bit demux select, and holds each word in a one-entry output register until the selected consumer accepts it. It sits directly upstream of the demux slice and owns its select lines.

## Interface
- W, 1: data width; 1 matches the single-bit demux input `a`
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- chan_en  in  4  per-channel enable, sampled at every channel choice
- in_valid  in  1  producer has a word
- in_data  in  W  producer word
- in_ready  out  1  scheduler accepts `in_data` this cycle
- sel  out  2  demux select of the held word (drives `s`)
- out_data  out  W  held word, common to all channels
- out_valid  out  4  one-hot, the selected channel's valid
- out_ready  in  4  per-channel consumer ready
- busy  out  1  output register occupied

## Operation
- FSM has two states: IDLE (register empty) and HOLD (register full).
- `ptr` (2 bits) is the next preferred channel.
- Choice function: the first enabled channel found by searching ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- `any_en` = OR of `chan_en`.
- `in_ready` = any_en AND (IDLE OR (HOLD AND out_ready[sel])). This is a combinational path from `out_ready` to `in_ready`.
- Accept (in_valid AND in_ready):
  - register ← in_data
  - sel ← chosen channel
  - ptr ← chosen + 1 (mod 4)
  - state ← HOLD
- Drain (HOLD AND out_ready[sel]) without accept: state ← IDLE; sel and out_data keep their values.
- Drain and accept in the same cycle: the new word replaces the old one. State stays HOLD.
- out_valid = decode(sel) when in HOLD, else 4'b0000.
- A held word always completes to its `sel` channel, even if `chan_en[sel]` drops while it waits.
- If any_en = 0: in_ready = 0, ptr is unchanged, and a held word still drains.
- busy = (state == HOLD).

## Timing
- Reset values:
  - state IDLE, ptr 0, sel 0, out_data 0
  - out_valid 0000, busy 0
  - in_ready = any_en (combinational)
- Latency: the word accepted at edge N is visible on out_valid/out_data from cycle N+1.
- Throughput: one word per cycle when the selected consumers are always ready.
- Reset during HOLD discards the held word. No out_valid pulse after reset.
- out_valid and out_data are stable while HOLD and not drained (AXI-style: valid is not retracted).

## Configuration
- DEMUX_SCHED_SKIP_EN defined (work-conserving mode):
  - The choice function first searches for a channel that is enabled AND has out_ready high, in order ptr..ptr+3.
  - If none qualifies, it falls back to the plain enabled search.
  - A stalled consumer is passed over.
- Not defined: strict round-robin over enabled channels. out_ready has no influence on the choice.

## Structure
- Package `demux_sched_pkg`:
  - typedef `chan_sel_t` (logic [1:0])
  - enum `sched_state_e` {IDLE, HOLD}
  - localparam NUM_CH = 4
  - function `rr_pick(en, ptr)` returning chan_sel_t
- Sub-module `demux4_onehot`: combinational; inputs valid and sel, output the 4-bit one-hot out_valid. It is the gate-level demux equivalent.
- Top module holds the FSM, ptr, and data register.

## Test plan
- Reset, chan_en=1111, all out_ready=1, in_valid held high, data 1,0,1,1,0:
  - sel sequence 0,1,2,3,0
  - out_valid 0001,0010,0100,1000,0001 on consecutive cycles
  - out_data follows the input sequence
- chan_en=0101, continuous input:
  - sel alternates 0,2,0,2
  - channels 1 and 3 never see valid
- Channel 1 selected and out_ready[1]=0 for 5 cycles:
  - out_valid=0010 and out_data are held
  - in_ready=0
  - out_ready[1]=1 lets the next word accept in the same cycle
- chan_en=0000 with in_valid=1: in_ready stays 0 and ptr is unchanged. Then set chan_en=1000: the first word goes to sel=3.
- Assert rst mid-HOLD: on the next cycle out_valid=0000, busy=0, ptr=0.
- With DEMUX_SCHED_SKIP_EN, ptr=1, out_ready=1101:
  - channel 2 is chosen
  - without the macro, channel 1 is chosen and the word waits
